// File: rtl/uart_tx_buffer.sv
// Circular byte FIFO that feeds the UART TX controller one byte at a time,
// issuing a single-cycle Data_valid launch paced by the controller's busy.
module uart_tx_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    WR_DATA,
    input  logic                     WR_EN,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVERFLOW,
    input  logic                     BUSY,
    output logic [DATA_WIDTH-1:0]    P_DATA,
    output logic                     Data_valid
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] PTR_INC = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]       wr_ptr_q;
    logic [ADDR_W:0]       wr_ptr_d;
    logic [ADDR_W:0]       rd_ptr_q;
    logic                  overflow_q;
    logic                  overflow_d;
    state_t                state_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  dv_q;
    logic                  wr_accept;
    logic                  pop;

    // Extra wrap bit on each pointer distinguishes full from empty.
    assign EMPTY = (wr_ptr_q == rd_ptr_q);
    assign FULL  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign COUNT = wr_ptr_q - rd_ptr_q;

    assign OVERFLOW   = overflow_q;
    assign P_DATA     = p_data_q;
    assign Data_valid = dv_q;

    // FULL is the pre-edge value, so a same-cycle pop never rescues a write.
    assign wr_accept = WR_EN && !FULL;
    assign pop       = (state_q == IDLE) && !EMPTY && !BUSY;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        overflow_d = overflow_q;
        if (WR_EN) begin
            if (FULL) begin
                overflow_d = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q + PTR_INC;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= WR_DATA;
        end
    end

    // Launcher: pop on the IDLE edge, pulse for one cycle, then wait for
    // the controller's busy to rise and fall before the next launch.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            p_data_q <= '0;
            dv_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    dv_q <= 1'b0;
                    if (pop) begin
                        p_data_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
                        rd_ptr_q <= rd_ptr_q + PTR_INC;
                        dv_q     <= 1'b1;
                        state_q  <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    dv_q    <= 1'b0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    dv_q <= 1'b0;
                    if (BUSY) begin
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    dv_q <= 1'b0;
                    if (!BUSY) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    dv_q    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Scoreboard bench for uart_tx_buffer with a small TX-controller busy model.
module tb_uart_tx_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          CLK;
    logic          RST;
    logic [DW-1:0] WR_DATA;
    logic          WR_EN;
    logic          FULL;
    logic          EMPTY;
    logic [AW:0]   COUNT;
    logic          OVERFLOW;
    logic          BUSY;
    logic [DW-1:0] P_DATA;
    logic          Data_valid;

    uart_tx_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .WR_DATA(WR_DATA), .WR_EN(WR_EN),
        .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT), .OVERFLOW(OVERFLOW),
        .BUSY(BUSY), .P_DATA(P_DATA), .Data_valid(Data_valid)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [DW-1:0] sb[$];
    int            m_cnt = 0;
    logic          m_ovf = 1'b0;
    logic [DW-1:0] last_pdata = '0;
    logic [DW-1:0] exp_b;
    int            n_dv = 0;
    int            last_wr_cyc = 0;
    logic          lat_chk = 1'b0;
    logic          prev_dv = 1'b0;
    logic          have_prev = 1'b0;
    logic          saw_hi = 1'b0;
    logic          saw_fall = 1'b0;
    logic          b;

    logic busy_m = 1'b0;
    logic busy_hold = 1'b0;
    int   tx_dly = 2;
    int   tx_len = 10;
    int   tx_cd = 0;
    int   tx_rem = 0;

    assign BUSY = busy_m | busy_hold;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // One write strobe; acceptance is decided from the model occupancy before the edge.
    task automatic wr(input logic [DW-1:0] d);
        WR_EN   = 1'b1;
        WR_DATA = d;
        @(posedge CLK);
        #1;
        if (RST) begin
            if (m_cnt < DEPTH) begin
                sb.push_back(d);
                m_cnt++;
            end else begin
                m_ovf = 1'b1;
            end
            last_wr_cyc = cyc;
        end
        WR_EN = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || m_cnt != 0 || busy_m || tx_cd != 0) && n < budget) begin
            idle(1);
            n++;
        end
        check_eq("drain_timeout", 32'(n < budget), 1);
        idle(3);
    endtask

    task automatic rst_pulse();
        RST = 1'b0;
        idle(2);
        RST = 1'b1;
        idle(1);
    endtask

    // Monitor + TX model, all on the falling edge.
    always @(negedge CLK) begin
        if (!RST) begin
            sb.delete();
            m_cnt = 0; m_ovf = 1'b0; last_pdata = '0;
            prev_dv = 1'b0; have_prev = 1'b0; saw_hi = 1'b0; saw_fall = 1'b0;
            busy_m = 1'b0; tx_cd = 0; tx_rem = 0; lat_chk = 1'b0;
            check_eq("rst_count", 32'(COUNT), 0);
            check_eq("rst_empty", 32'(EMPTY), 1);
            check_eq("rst_full", 32'(FULL), 0);
            check_eq("rst_ovf", 32'(OVERFLOW), 0);
            check_eq("rst_dv", 32'(Data_valid), 0);
            check_eq("rst_pdata", 32'(P_DATA), 0);
        end else begin
            b = BUSY;
            if (b) saw_hi = 1'b1;
            else if (saw_hi) saw_fall = 1'b1;
            if (Data_valid) begin
                n_dv++;
                check_eq("dv_consecutive", 32'(prev_dv), 0);
                if (have_prev) check_eq("pacing", 32'(saw_fall), 1);
                have_prev = 1'b1; saw_hi = 1'b0; saw_fall = 1'b0;
                if (sb.size() == 0) begin
                    check_eq("dv_unexpected", 1, 0);
                end else begin
                    exp_b = sb.pop_front();
                    check_eq("launch_data", 32'(P_DATA), 32'(exp_b));
                    last_pdata = exp_b;
                    m_cnt--;
                end
                if (lat_chk) begin
                    check_eq("latency", 32'(cyc - last_wr_cyc), 1);
                    lat_chk = 1'b0;
                end
            end
            check_eq("pdata_hold", 32'(P_DATA), 32'(last_pdata));
            check_eq("count", 32'(COUNT), 32'(m_cnt));
            check_eq("empty", 32'(EMPTY), 32'(m_cnt == 0));
            check_eq("full", 32'(FULL), 32'(m_cnt == DEPTH));
            check_eq("overflow", 32'(OVERFLOW), 32'(m_ovf));
            prev_dv = Data_valid;
            if (tx_cd > 0) begin
                tx_cd--;
                if (tx_cd == 0) begin
                    busy_m = 1'b1;
                    tx_rem = tx_len;
                end
            end else if (busy_m) begin
                tx_rem--;
                if (tx_rem == 0) busy_m = 1'b0;
            end
            if (Data_valid) tx_cd = tx_dly;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int n;
        RST = 1'b1; WR_EN = 1'b0; WR_DATA = '0;
        #2 RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK);
            #1;
            WR_EN   = ~WR_EN;
            WR_DATA = 8'h5A;
        end
        check_eq("reset_empty", 32'(EMPTY), 1);
        check_eq("reset_full", 32'(FULL), 0);
        check_eq("reset_count", 32'(COUNT), 0);
        check_eq("reset_ovf", 32'(OVERFLOW), 0);
        check_eq("reset_dv", 32'(Data_valid), 0);
        check_eq("reset_pdata", 32'(P_DATA), 0);
        WR_EN = 1'b0;
        RST   = 1'b1;
        idle(2);

        // Single byte into an empty idle buffer
        tx_dly = 2; tx_len = 10;
        n0 = n_dv;
        lat_chk = 1'b1;
        wr(8'hA5);
        check_eq("single_cnt1", 32'(COUNT), 1);
        check_eq("single_empty", 32'(EMPTY), 0);
        idle(1);
        check_eq("single_dv", 32'(Data_valid), 1);
        check_eq("single_pdata", 32'(P_DATA), 32'hA5);
        check_eq("single_cnt0", 32'(COUNT), 0);
        drain(200);
        check_eq("single_pulses", 32'(n_dv - n0), 1);
        check_eq("single_pdata_held", 32'(P_DATA), 32'hA5);

        // Burst to overflow while the controller is busy
        tx_len = 4;
        busy_hold = 1'b1;
        idle(1);
        for (int i = 1; i <= 9; i++) wr(8'(i));
        check_eq("burst_full", 32'(FULL), 1);
        check_eq("burst_count", 32'(COUNT), 8);
        check_eq("burst_ovf", 32'(OVERFLOW), 1);
        check_eq("burst_queued", 32'(sb.size()), 8);
        n0 = n_dv;
        busy_hold = 1'b0;
        drain(1000);
        check_eq("burst_pulses", 32'(n_dv - n0), 8);
        check_eq("burst_empty", 32'(EMPTY), 1);
        check_eq("burst_ovf_sticky", 32'(OVERFLOW), 1);
        check_eq("burst_last", 32'(P_DATA), 32'h08);

        // Pop and write on the same edge at COUNT=3
        rst_pulse();
        busy_hold = 1'b1;
        idle(1);
        wr(8'h10); wr(8'h11); wr(8'h12);
        check_eq("sim_cnt_pre", 32'(COUNT), 3);
        busy_hold = 1'b0;
        wr(8'h13);
        check_eq("sim_cnt", 32'(COUNT), 3);
        check_eq("sim_dv", 32'(Data_valid), 1);
        check_eq("sim_pdata", 32'(P_DATA), 32'h10);
        drain(500);
        check_eq("sim_last", 32'(P_DATA), 32'h13);

        // Extended serializer delay before busy rises
        tx_dly = 4; tx_len = 3;
        n0 = n_dv;
        wr(8'h21); wr(8'h22); wr(8'h23);
        drain(500);
        check_eq("pace_pulses", 32'(n_dv - n0), 3);
        check_eq("pace_last", 32'(P_DATA), 32'h23);

        // Reset while transmitting with bytes queued
        tx_dly = 1; tx_len = 30;
        wr(8'h31); wr(8'h32); wr(8'h33); wr(8'h34); wr(8'h35);
        n = 0;
        while (!busy_m && n < 50) begin
            idle(1);
            n++;
        end
        check_eq("mid_busy", 32'(busy_m), 1);
        idle(2);
        check_eq("mid_cnt", 32'(COUNT), 4);
        RST = 1'b0;
        #1;
        check_eq("mid_rst_count", 32'(COUNT), 0);
        check_eq("mid_rst_empty", 32'(EMPTY), 1);
        check_eq("mid_rst_full", 32'(FULL), 0);
        check_eq("mid_rst_ovf", 32'(OVERFLOW), 0);
        check_eq("mid_rst_dv", 32'(Data_valid), 0);
        check_eq("mid_rst_pdata", 32'(P_DATA), 0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        n0 = n_dv;
        idle(20);
        check_eq("mid_quiet", 32'(n_dv - n0), 0);
        tx_dly = 2; tx_len = 5;
        wr(8'h77);
        drain(200);
        check_eq("mid_new_pulses", 32'(n_dv - n0), 1);
        check_eq("mid_new_pdata", 32'(P_DATA), 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
